// File: rtl/parity_rx_checker.sv
// ----------------------------------------------------------------------------
// parity_rx_checker: LSB-first serial frame deserialiser with XOR/XNOR parity check
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module parity_rx_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              in_start,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              par_err,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
  localparam logic ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_par_q, run_par_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              par_err_q, par_err_d;
  logic              busy_q, busy_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              mismatch;

  assign mismatch = in_bit ^ run_par_q ^ ODD_BIT;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    run_par_d   = run_par_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    par_err_d   = par_err_q;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      // A start always wins: it abandons any frame in flight, even in PARITY.
      if (in_start) begin
        shift_d   = {in_bit, {(DATA_W-1){1'b0}}};
        run_par_d = in_bit;
        cnt_d     = CNT_W'(1);
        state_d   = DATA;
      end else begin
        case (state_q)
          DATA: begin
            // Right-shifting register: the first bit lands at bit 0 after DATA_W shifts.
            shift_d   = {in_bit, shift_q[DATA_W-1:1]};
            run_par_d = run_par_q ^ in_bit;
            if (cnt_q == LAST_IDX) begin
              state_d = PARITY;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          PARITY: begin
            out_valid_d = 1'b1;
            out_data_d  = shift_q;
            par_err_d   = mismatch;
            if (mismatch && (err_cnt_q != 8'hFF)) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
            state_d = IDLE;
          end
          default: ;
        endcase
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      run_par_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      par_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      run_par_q   <= run_par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      par_err_q   <= par_err_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign par_err   = par_err_q;
  assign busy      = busy_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: doc/parity_rx_checker.md
# parity_rx_checker

Serial receive-side checker for XOR-based parity frames: the consuming end of the team's XOR/XNOR parity generation path. Shifts in DATA_W data bits LSB-first plus one parity bit. It recomputes parity with a running XOR, or XNOR for odd parity, and presents the deserialised word with an error flag. Sits between the serial link front end and the word-level consumer; also keeps a saturating count of bad frames.

## Interface
- DATA_W, 8, data bits per frame (2..32)
- ODD, 0, 0 = even parity (expected bit = XOR of data), 1 = odd parity (expected bit = XNOR of data)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_bit/in_start valid this cycle
- in_bit  input  1  serial bit, LSB-first data then parity
- in_start  input  1  qualified by in_valid; marks data bit 0 of a frame
- out_valid  output  1  one-cycle pulse: frame complete
- out_data  output  DATA_W  received data word
- par_err  output  1  1 = received parity mismatched expected
- busy  output  1  frame in progress (DATA or PARITY state)
- err_cnt  output  8  count of frames with par_err, saturates at 255

## Operation
- States: IDLE, DATA, PARITY.
- IDLE: in_valid&in_start → bit captured as data bit 0, running parity = in_bit, bit count = 1, go DATA (PARITY if DATA_W==1, not supported; DATA_W≥2). in_valid without in_start ignored.
- DATA: each in_valid bit stored at position bit count, running parity ^= in_bit, count++. After bit DATA_W-1 accepted → PARITY.
- PARITY: in_valid bit compared with expected (running, or ~running if ODD). Registers out_data, par_err; pulses out_valid; increments err_cnt if mismatch and err_cnt<255; → IDLE.
- in_valid low: everything holds; stalls of any length allowed mid-frame.
- in_valid&in_start in DATA or PARITY: current frame abandoned silently (no out_valid, no err_cnt change). The bit is taken as bit 0 of a new frame, count=1, state DATA.
- out_data/par_err hold last completed frame's values until the next out_valid.
- busy = (state != IDLE).

## Timing
- Reset (rst high at an edge): state IDLE, out_valid=0, out_data=0, par_err=0, busy=0, err_cnt=0, internal count/parity cleared. Applies mid-frame; partial frame discarded, no out_valid.
- All outputs registered. out_valid, out_data, par_err, err_cnt update at the same edge that samples the parity bit; out_valid high exactly one cycle.
- Minimum frame: DATA_W+1 consecutive valid cycles. A new in_start may be accepted the cycle immediately after the parity bit (during the out_valid cycle); no dead cycle.
- Restart on in_start in PARITY state takes priority over parity check.
- err_cnt at 255 stays 255; par_err still reported.

## Test plan
- DATA_W=8, ODD=0: rst, then bits 1,0,1,0,0,1,0,1 (0xA5, start on first) + parity 0 back-to-back → out_valid one cycle after 9th bit edge, out_data=0xA5, par_err=0, err_cnt=0.
- Same frame, parity 1 → par_err=1, err_cnt=1. Immediately follow with 0x01 + parity 1 (no gap) → out_data=0x01, par_err=0, err_cnt=1.
- ODD=1: 0xA5 + parity 1 → par_err=0; 0xA5 + parity 0 → par_err=1.
- Stall: 0x3C + parity 0 with in_valid low 3 cycles between every bit → out_data=0x3C, par_err=0, busy high throughout; out_data holds until next frame.
- Abort: in_start after 5 bits, then full 0xFF + parity 0 → exactly one out_valid, out_data=0xFF, par_err=0. rst after 4 bits → busy=0, no out_valid, all outputs 0.
- Saturation: 257 bad-parity frames → err_cnt reaches 255 and stays; par_err=1 on each.
